// File: rtl/snoop_ctrl_lv1.sv
// Snoop-side MESI controller for one L1: accepts one bus snoop at a time, looks up
// the line, optionally flushes it, updates its MESI state and pulses a response.
`ifndef ASSOC_LV1
`define ASSOC_LV1 4
`endif
`ifndef ASSOC_WID_LV1
`define ASSOC_WID_LV1 2
`endif

module snoop_ctrl_lv1 #(
  parameter int ASSOC     = `ASSOC_LV1,
  parameter int ASSOC_WID = `ASSOC_WID_LV1,
  parameter int ADDR_WID  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 snoop_req_valid,
  input  logic [1:0]           snoop_req_type,
  input  logic [ADDR_WID-1:0]  snoop_addr,
  output logic                 snoop_req_ready,
  input  logic                 cpu_busy,
  output logic [ADDR_WID-1:0]  lookup_addr,
  input  logic                 blk_hit_snoop,
  input  logic [ASSOC_WID-1:0] blk_access_snoop,
  input  logic [1:0]           mesi_state_snoop,
  output logic                 mesi_wr_en,
  output logic [ASSOC_WID-1:0] mesi_wr_way,
  output logic [1:0]           mesi_wr_state,
  output logic                 flush_req,
  output logic [ASSOC_WID-1:0] flush_way,
  input  logic                 flush_done,
  output logic                 snoop_resp_valid,
  output logic                 snoop_resp_shared,
  output logic                 snoop_resp_flush
);

  if (ASSOC > (1 << ASSOC_WID)) begin : g_bad_assoc
    $error("ASSOC does not fit in ASSOC_WID");
  end

  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
  localparam logic [1:0] T_RD = 2'b00, T_RDX = 2'b01, T_INV = 2'b10;

  typedef enum logic [2:0] {IDLE, LOOKUP, FLUSH, UPDATE, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WID-1:0]   addr_q, addr_d;
  logic [1:0]            type_q, type_d;
  logic [ASSOC_WID-1:0]  way_q, way_d;
  logic [1:0]            wst_q, wst_d;
  logic                  shr_q, shr_d;
  logic                  fl_q, fl_d;
  logic                  line_hit;

  // A tag hit on an Invalid line is a miss.
  assign line_hit    = blk_hit_snoop && (mesi_state_snoop != ST_I);
  assign lookup_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      type_q  <= '0;
      way_q   <= '0;
      wst_q   <= ST_I;
      shr_q   <= 1'b0;
      fl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      way_q   <= way_d;
      wst_q   <= wst_d;
      shr_q   <= shr_d;
      fl_q    <= fl_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    type_d            = type_q;
    way_d             = way_q;
    wst_d             = wst_q;
    shr_d             = shr_q;
    fl_d              = fl_q;
    snoop_req_ready   = 1'b0;
    mesi_wr_en        = 1'b0;
    mesi_wr_way       = '0;
    mesi_wr_state     = ST_I;
    flush_req         = 1'b0;
    flush_way         = '0;
    snoop_resp_valid  = 1'b0;
    snoop_resp_shared = 1'b0;
    snoop_resp_flush  = 1'b0;
    case (state_q)
      IDLE: begin
        snoop_req_ready = !cpu_busy;
        if (snoop_req_valid && !cpu_busy) begin
          addr_d  = snoop_addr;
          type_d  = snoop_req_type;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        way_d   = blk_access_snoop;
        wst_d   = ST_I;
        shr_d   = 1'b0;
        fl_d    = 1'b0;
        state_d = RESP;
        if (line_hit) begin
          case (type_q)
            T_RD: begin
              shr_d = 1'b1;
              wst_d = ST_S;
              if (mesi_state_snoop == ST_E) state_d = UPDATE;
              if (mesi_state_snoop == ST_M) begin
                fl_d    = 1'b1;
                state_d = FLUSH;
              end
            end
            T_RDX: begin
              fl_d    = (mesi_state_snoop == ST_M);
              state_d = (mesi_state_snoop == ST_M) ? FLUSH : UPDATE;
            end
            T_INV:   state_d = UPDATE;
            default: state_d = RESP;
          endcase
        end
      end
      FLUSH: begin
        flush_req = 1'b1;
        flush_way = way_q;
        if (flush_done) state_d = UPDATE;
      end
      UPDATE: begin
        mesi_wr_en    = 1'b1;
        mesi_wr_way   = way_q;
        mesi_wr_state = wst_q;
        state_d       = RESP;
      end
      RESP: begin
        snoop_resp_valid  = 1'b1;
        snoop_resp_shared = shr_q;
        snoop_resp_flush  = fl_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts immediately: nothing may leave the block in the reset cycle.
    if (rst) begin
      snoop_req_ready   = 1'b0;
      mesi_wr_en        = 1'b0;
      mesi_wr_way       = '0;
      mesi_wr_state     = ST_I;
      flush_req         = 1'b0;
      flush_way         = '0;
      snoop_resp_valid  = 1'b0;
      snoop_resp_shared = 1'b0;
      snoop_resp_flush  = 1'b0;
    end
  end

endmodule

// File: tb/tb_snoop_ctrl_lv1.sv
// Scoreboard bench for snoop_ctrl_lv1: a 4-line tag model answers lookups,
// expected write/flush/response events are queued at accept and checked on output.
module tb_snoop_ctrl_lv1;
  localparam int AW = 32;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          snoop_req_valid;
  logic [1:0]    snoop_req_type;
  logic [AW-1:0] snoop_addr;
  logic          snoop_req_ready;
  logic          cpu_busy;
  logic [AW-1:0] lookup_addr;
  logic          blk_hit_snoop;
  logic [WW-1:0] blk_access_snoop;
  logic [1:0]    mesi_state_snoop;
  logic          mesi_wr_en;
  logic [WW-1:0] mesi_wr_way;
  logic [1:0]    mesi_wr_state;
  logic          flush_req;
  logic [WW-1:0] flush_way;
  logic          flush_done;
  logic          snoop_resp_valid;
  logic          snoop_resp_shared;
  logic          snoop_resp_flush;

  always #5 clk = ~clk;

  snoop_ctrl_lv1 #(.ASSOC(4), .ASSOC_WID(WW), .ADDR_WID(AW)) dut (
    .clk(clk), .rst(rst),
    .snoop_req_valid(snoop_req_valid), .snoop_req_type(snoop_req_type),
    .snoop_addr(snoop_addr), .snoop_req_ready(snoop_req_ready),
    .cpu_busy(cpu_busy), .lookup_addr(lookup_addr),
    .blk_hit_snoop(blk_hit_snoop), .blk_access_snoop(blk_access_snoop),
    .mesi_state_snoop(mesi_state_snoop),
    .mesi_wr_en(mesi_wr_en), .mesi_wr_way(mesi_wr_way), .mesi_wr_state(mesi_wr_state),
    .flush_req(flush_req), .flush_way(flush_way), .flush_done(flush_done),
    .snoop_resp_valid(snoop_resp_valid), .snoop_resp_shared(snoop_resp_shared),
    .snoop_resp_flush(snoop_resp_flush)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
  endtask

  // Tag model: entry index is the way.
  logic [AW-1:0] m_addr [4];
  logic [1:0]    m_st   [4];

  always_comb begin
    blk_hit_snoop    = 1'b0;
    blk_access_snoop = '0;
    mesi_state_snoop = 2'b00;
    for (int i = 0; i < 4; i++)
      if (m_addr[i] == lookup_addr) begin
        blk_hit_snoop    = 1'b1;
        blk_access_snoop = i[WW-1:0];
        mesi_state_snoop = m_st[i];
      end
  end

  // Flush responder: pulse flush_done in the fl_dly-th cycle of flush_req (0 = never).
  int   fl_dly = 0;
  int   fcnt = 0;
  logic fd_auto = 1'b0;
  logic fd_man = 1'b0;
  assign flush_done = fd_auto | fd_man;
  initial forever begin
    @(negedge clk);
    if (flush_req && fl_dly > 0) begin
      fcnt++;
      fd_auto = (fcnt == fl_dly);
    end else begin
      fcnt    = 0;
      fd_auto = 1'b0;
    end
  end

  typedef struct {
    bit       wr;
    bit [1:0] way;
    bit [1:0] wst;
    bit       shr;
    bit       fl;
    int       fl_cyc;
    int       wr_cyc;
    int       resp_cyc;
  } exp_t;
  exp_t q[$];

  int wr_seen = 0;
  int fl_seen = 0;

  // Output monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (mesi_wr_en) begin
      if (q.size() == 0) chk("spur_wr", 1, 0);
      else begin
        chk("wr_exp", 1, q[0].wr);
        chk("wr_way", mesi_wr_way, q[0].way);
        chk("wr_state", mesi_wr_state, q[0].wst);
        chk("wr_cyc", cyc, q[0].wr_cyc);
        wr_seen++;
      end
    end
    if (flush_req) begin
      if (q.size() == 0) chk("spur_flush", 1, 0);
      else begin
        chk("flush_way", flush_way, q[0].way);
        fl_seen++;
      end
    end
    if (snoop_resp_valid) begin
      if (q.size() == 0) chk("spur_resp", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_shared", snoop_resp_shared, e.shr);
        chk("resp_flush", snoop_resp_flush, e.fl);
        chk("resp_cyc", cyc, e.resp_cyc);
        chk("wr_count", wr_seen, e.wr ? 1 : 0);
        chk("flush_cycles", fl_seen, e.fl_cyc);
      end
      wr_seen = 0;
      fl_seen = 0;
    end
  end

  // Drive one request until accepted; queue the expected outcome at accept.
  task automatic do_req(input logic [1:0] t, input logic [AW-1:0] a, input int fdly, output int T);
    exp_t e;
    logic hit;
    logic [1:0] st, way;
    hit = 0; st = 0; way = 0;
    for (int i = 0; i < 4; i++)
      if (m_addr[i] == a) begin hit = 1; st = m_st[i]; way = i[1:0]; end
    e = '{wr: 0, way: way, wst: 0, shr: 0, fl: 0, fl_cyc: 0, wr_cyc: 0, resp_cyc: 0};
    if (hit && st != 2'b00) begin
      case (t)
        2'b00: begin e.shr = 1; e.wr = (st != 2'b01); e.wst = 2'b01; e.fl = (st == 2'b11); end
        2'b01: begin e.wr = 1; e.wst = 2'b00; e.fl = (st == 2'b11); end
        2'b10: begin e.wr = 1; e.wst = 2'b00; end
        default: ;
      endcase
    end
    fl_dly = fdly;
    snoop_req_valid = 1'b1;
    snoop_req_type  = t;
    snoop_addr      = a;
    T = -1;
    for (int k = 0; k < 50 && T < 0; k++) begin
      @(negedge clk);
      if (snoop_req_ready) begin
        T = cyc;
        e.fl_cyc   = e.fl ? fdly : 0;
        e.wr_cyc   = e.fl ? T + 2 + fdly : T + 2;
        e.resp_cyc = e.wr ? e.wr_cyc + 1 : T + 2;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    snoop_req_valid = 1'b0;
    if (T < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin @(negedge clk); k++; end
    if (q.size() != 0) begin chk("resp_timeout", q.size(), 0); q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_outs"}, {mesi_wr_en, flush_req, snoop_resp_valid, snoop_resp_shared,
                         snoop_resp_flush, mesi_wr_way, mesi_wr_state, flush_way}, 0);
    chk({tag, "_laddr"}, lookup_addr, 0);
  endtask

  int t1, t2, c0;

  initial begin
    rst = 1'b1; snoop_req_valid = 0; snoop_req_type = 0; snoop_addr = 0; cpu_busy = 0;
    m_addr[0] = 32'h4000; m_st[0] = 2'b01;
    m_addr[1] = 32'h5000; m_st[1] = 2'b11;
    m_addr[2] = 32'h6000; m_st[2] = 2'b10;
    m_addr[3] = 32'h7000; m_st[3] = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk); chk_quiet("in_reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");
    chk("post_reset_ready", snoop_req_ready, 1);
    @(posedge clk); #1;

    do_req(2'b00, 32'h1000, 0, t1); wait_done();   // BusRd miss
    do_req(2'b00, 32'h6000, 0, t1); wait_done();   // BusRd E way 2
    do_req(2'b01, 32'h5000, 3, t1); wait_done();   // BusRdX M way 1, flush 3 cycles

    // cpu_busy holds off acceptance
    cpu_busy = 1; snoop_req_valid = 1; snoop_req_type = 2'b00; snoop_addr = 32'h7000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("busy_ready", snoop_req_ready, 0);
      @(posedge clk); #1;
    end
    cpu_busy = 0; c0 = cyc;
    do_req(2'b00, 32'h7000, 0, t1);
    chk("busy_accept_cyc", t1, c0);
    wait_done();

    // Reset in the middle of a flush
    do_req(2'b01, 32'h5000, 0, t1);
    for (int k = 0; k < 10 && !flush_req; k++) @(negedge clk);
    chk("flush_started", flush_req, 1);
    @(posedge clk); #1 rst = 1'b1; q.delete(); wr_seen = 0; fl_seen = 0;
    @(negedge clk); chk("rst_cycle_flush", flush_req, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk_quiet("after_abort"); chk("after_abort_ready", snoop_req_ready, 1);
    @(posedge clk); #1 fd_man = 1'b1;
    @(posedge clk); #1 fd_man = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Invalidate S way 0 with a second request held valid behind it
    do_req(2'b10, 32'h4000, 0, t1);
    do_req(2'b00, 32'h1000, 0, t2);
    chk("b2b_spacing", (t2 >= t1 + 4), 1);
    wait_done();

    do_req(2'b11, 32'h5000, 0, t1); wait_done();   // reserved type: no-op miss
    do_req(2'b00, 32'h5000, 1, t1); wait_done();   // BusRd M, flush 1 cycle
    do_req(2'b01, 32'h7000, 0, t1); wait_done();   // BusRdX S
    do_req(2'b10, 32'h5000, 0, t1); wait_done();   // Invalidate M: no flush
    m_st[3] = 2'b00;
    do_req(2'b01, 32'h7000, 0, t1); wait_done();   // hit on I line counts as miss
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/snoop_ctrl_lv1.md
Name: snoop_ctrl_lv1

Overview:
Snoop-side controller for one L1 cache in the 4-core MESI system. It accepts one bus snoop request at a time and sequences a tag/MESI lookup using the snoop-side hit and way-select results. From the snooped line's state it decides whether to flush data, writes the next MESI state, and returns a one-cycle snoop response with a shared indication. It sits between the bus snoop port and the L1 tag/MESI arrays, and the CPU-side controller can hold it off from starting.

Parameters:
ASSOC, `ASSOC_LV1, number of ways
ASSOC_WID, `ASSOC_WID_LV1, way index width
ADDR_WID, 32, snoop address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
snoop_req_valid  in  1  bus snoop request present
snoop_req_type  in  2  00 BusRd, 01 BusRdX, 10 Invalidate, 11 reserved (treated as no-op miss)
snoop_addr  in  ADDR_WID  snooped address
snoop_req_ready  out  1  request accepted when valid&&ready
cpu_busy  in  1  CPU side owns tag/MESI arrays this cycle
lookup_addr  out  ADDR_WID  latched address driven to snoop tag compare
blk_hit_snoop  in  1  snoop tag hit for lookup_addr (combinational from arrays)
blk_access_snoop  in  ASSOC_WID  hit way index
mesi_state_snoop  in  2  MESI state of hit way: I=00, S=01, E=10, M=11
mesi_wr_en  out  1  MESI state write strobe
mesi_wr_way  out  ASSOC_WID  way to write
mesi_wr_state  out  2  new state
flush_req  out  1  request data-side flush of hit way to bus
flush_way  out  ASSOC_WID  way to flush
flush_done  in  1  flush complete (single-cycle pulse)
snoop_resp_valid  out  1  one-cycle response pulse
snoop_resp_shared  out  1  line held valid here (BusRd only)
snoop_resp_flush  out  1  this cache supplied data

Behaviour:
- Reset: state IDLE. All outputs 0; lookup_addr 0. No MESI write or flush is issued in the reset cycle or the cycle after.
- Reset mid-operation aborts the transaction. Any pending flush_req drops and no response is sent.
- FSM states: IDLE, LOOKUP, FLUSH, UPDATE, RESP.
- IDLE: snoop_req_ready = !cpu_busy (combinational). On valid&&ready, latch addr and type into lookup_addr and a type register, then go to LOOKUP.
- LOOKUP (exactly 1 cycle): sample blk_hit_snoop, blk_access_snoop and mesi_state_snoop into registers. A hit with state I is treated as a miss. Decide as follows:
  - miss, or reserved type: RESP; shared=0, flush=0, no write.
  - BusRd, S: RESP, shared=1, no write.
  - BusRd, E: UPDATE to S, shared=1.
  - BusRd, M: FLUSH, then UPDATE to S; shared=1, flush=1.
  - BusRdX, S/E: UPDATE to I, shared=0.
  - BusRdX, M: FLUSH, then UPDATE to I; flush=1.
  - Invalidate, S/E/M: UPDATE to I, no flush.
- FLUSH: hold flush_req=1 and flush_way=latched way until a cycle where flush_done=1. flush_req deasserts the following cycle, when the FSM enters UPDATE. There is no timeout.
- UPDATE (1 cycle): mesi_wr_en=1, with mesi_wr_way and mesi_wr_state driven. Next state RESP.
- RESP (1 cycle): snoop_resp_valid=1 with shared/flush flags; all three outputs are 0 in every other cycle. Next state IDLE. snoop_req_ready stays 0 during RESP, so back-to-back requests are spaced by at least one idle cycle.
- Latency from the accept cycle T:
  - no write: resp at T+2.
  - write, no flush: mesi_wr_en at T+2, resp at T+3.
  - flush: flush_req from T+2; if flush_done arrives at cycle F, mesi_wr_en at F+1 and resp at F+2.
- cpu_busy only gates acceptance in IDLE. Once a request is accepted, the transaction completes regardless of cpu_busy.
- snoop_addr and type are ignored outside the accept cycle.
- flush_done outside FLUSH is ignored.

Test Plan:
- Reset, then BusRd to a missing addr 0x1000 accepted at T → resp at T+2 with shared=0, flush=0; mesi_wr_en never asserts.
- BusRd hitting way 2 in E → mesi_wr_en at T+2 with way=2, state=S; resp at T+3 with shared=1.
- BusRdX hitting way 1 in M, flush_done 3 cycles after flush_req rises → flush_req high exactly 3 cycles with flush_way=1, then a write of I to way 1, then resp with flush=1, shared=0.
- snoop_req_valid=1 with cpu_busy=1 for 4 cycles → ready=0 and no accept; cpu_busy drops → accept in that same cycle.
- Assert rst during FLUSH → next cycle all outputs 0 and state IDLE; a later flush_done pulse produces no write or response.
- Invalidate hitting way 0 in S, then a second request held valid → write I to way 0 at T+2 and resp at T+3; second request accepted no earlier than T+4.
